// File: rtl/regression_predictor.sv
// Host-side sequencer for the regression engine plus a 2-stage y = b_0 + b_1*x query pipeline.
// Build option: define REGPRED_SAT_EN to clamp out-of-range predictions instead of wrapping.
module regression_predictor #(
   parameter int FRAC    = 10,
   parameter int TIMEOUT = 4096,
   parameter int DATA_W  = 20,
   parameter int COEF_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              train,
   output logic              reg_start,
   input  logic              reg_ready,
   input  logic [COEF_W-1:0] reg_b1,
   input  logic [COEF_W-1:0] reg_b0,
   input  logic              q_valid,
   output logic              q_ready,
   input  logic [DATA_W-1:0] q_x,
   output logic              p_valid,
   input  logic              p_ready,
   output logic [DATA_W-1:0] p_y,
   output logic              p_sat,
   output logic              coef_valid,
   output logic              busy,
   output logic              timeout
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, DRAIN, START, WAIT_LO, WAIT_HI, LOADED, ERR} state_t;

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           cnt;
   logic                       last_cycle, capture, expire;
   logic                       coef_vld, tmo;
   logic signed [COEF_W-1:0]   b1_q, b0_q;
   logic                       stall, accept;
   logic                       vld_p1, vld_p2;
   logic signed [PROD_W-1:0]   b1_x, x_x, prod_p1;
   logic signed [DATA_W-1:0]   y_p2;
   logic                       sat_p2;

   // Product shifted down to the output scale (floor) plus the sign-extended intercept.
   function automatic logic signed [SUM_W-1:0] scale_add(input logic signed [PROD_W-1:0] prod,
                                                        input logic signed [COEF_W-1:0] b0);
      logic signed [SUM_W-1:0] prod_w, b0_w;
      prod_w = {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      b0_w   = {{(SUM_W-COEF_W){b0[COEF_W-1]}}, b0};
      return (prod_w >>> FRAC) + b0_w;
   endfunction

   // Returns {sat, y}: clamp to the DATA_W signed range when enabled, else two's-complement wrap.
   function automatic logic [DATA_W:0] reduce(input logic signed [SUM_W-1:0] sum);
`ifdef REGPRED_SAT_EN
      logic ovf;
      ovf = (sum[SUM_W-1:DATA_W-1] != {(SUM_W-DATA_W+1){sum[SUM_W-1]}});
      if (ovf)
         return {1'b1, sum[SUM_W-1], {(DATA_W-1){~sum[SUM_W-1]}}};
      else
         return {1'b0, sum[DATA_W-1:0]};
`else
      return {1'b0, sum[DATA_W-1:0]};
`endif
   endfunction

   assign last_cycle = (cnt == CNT_W'(TIMEOUT - 1));
   assign stall      = vld_p2 && !p_ready;
   assign q_ready    = (state == LOADED) && !stall && !train;
   assign accept     = q_valid && q_ready;

   always_comb begin
      state_nxt = state;
      reg_start = 1'b0;
      busy      = 1'b0;
      capture   = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE, ERR: if (train) state_nxt = START;
         LOADED:    if (train) state_nxt = DRAIN;
         DRAIN: begin
            busy = 1'b1;
            if (!vld_p1 && !vld_p2) state_nxt = START;
         end
         START: begin
            busy      = 1'b1;
            reg_start = 1'b1;
            state_nxt = WAIT_LO;
         end
         WAIT_LO: begin
            busy = 1'b1;
            if (last_cycle) begin
               expire    = 1'b1;
               state_nxt = ERR;
            end else if (!reg_ready) begin
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            busy = 1'b1;
            // A completion on the final allowed cycle takes priority over the timeout.
            if (reg_ready) begin
               capture   = 1'b1;
               state_nxt = LOADED;
            end else if (last_cycle) begin
               expire    = 1'b1;
               state_nxt = ERR;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         coef_vld <= 1'b0;
         tmo      <= 1'b0;
         b1_q     <= '0;
         b0_q     <= '0;
      end else begin
         state <= state_nxt;
         if (state == START) begin
            cnt      <= '0;
            coef_vld <= 1'b0;
         end else if (state == WAIT_LO || state == WAIT_HI) begin
            cnt <= cnt + 1'b1;
         end
         if (capture) begin
            b1_q     <= $signed(reg_b1);
            b0_q     <= $signed(reg_b0);
            coef_vld <= 1'b1;
            tmo      <= 1'b0;
         end
         if (expire) begin
            tmo      <= 1'b1;
            coef_vld <= 1'b0;
         end
      end
   end

   assign coef_valid = coef_vld;
   assign timeout    = tmo;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (!stall) begin
         vld_p1 <= accept;
         vld_p2 <= vld_p1;
      end
   end

   // Stage 1: full-precision product b_1 * x
   assign b1_x = {{(PROD_W-COEF_W){b1_q[COEF_W-1]}}, b1_q};
   assign x_x  = {{(PROD_W-DATA_W){q_x[DATA_W-1]}}, q_x};

   always_ff @(posedge clk) begin
      if (!stall && accept)
         prod_p1 <= b1_x * x_x;
   end

   // Stage 2: rescale, add intercept, reduce to output width
   always_ff @(posedge clk) begin
      if (!rst) begin
         y_p2   <= '0;
         sat_p2 <= 1'b0;
      end else if (!stall && vld_p1) begin
         {sat_p2, y_p2} <= reduce(scale_add(prod_p1, b0_q));
      end
   end

   assign p_valid = vld_p2;
   assign p_y     = y_p2;
   assign p_sat   = sat_p2;

endmodule

// File: tb/tb_regression_predictor.sv
// Self-checking bench for regression_predictor: engine handshake, query table,
// randomized backpressure stream against a reference model, drain, timeout, reset.
module tb_regression_predictor;

   localparam int FRAC = 10;
   localparam int TMO  = 64;

   logic        clk = 1'b0;
   logic        rst, train, reg_start, reg_ready;
   logic [19:0] reg_b1, reg_b0;
   logic        q_valid, q_ready;
   logic [19:0] q_x;
   logic        p_valid, p_ready, p_sat, coef_valid, busy, timeout;
   logic [19:0] p_y;

   regression_predictor #(.FRAC(FRAC), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .train(train), .reg_start(reg_start), .reg_ready(reg_ready),
      .reg_b1(reg_b1), .reg_b0(reg_b0), .q_valid(q_valid), .q_ready(q_ready), .q_x(q_x),
      .p_valid(p_valid), .p_ready(p_ready), .p_y(p_y), .p_sat(p_sat),
      .coef_valid(coef_valid), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int start_pulses = 0;

   // reg_start is a registered one-cycle level; sampling mid-cycle counts each pulse once.
   always @(negedge clk) if (reg_start) start_pulses++;

   typedef struct {
      logic [19:0] x;
      logic [19:0] y;
      logic        sat;
   } vec_t;

   vec_t        vt[8];
   logic [20:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // y = b0 + floor(b1*x / 2^FRAC), then clamp or wrap into 20 signed bits.
   function automatic logic [20:0] model(input logic [19:0] b1, input logic [19:0] b0,
                                         input logic [19:0] x);
      longint p, q, s, one;
      one = longint'(1) << FRAC;
      p = longint'($signed(b1)) * longint'($signed(x));
      q = p / one;
      if (p < 0 && q * one != p) q = q - 1;
      s = q + longint'($signed(b0));
`ifdef REGPRED_SAT_EN
      if (s > 524287)  return {1'b1, 20'h7FFFF};
      if (s < -524288) return {1'b1, 20'h80000};
`endif
      return {1'b0, s[19:0]};
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_reg_start"},  reg_start,  0);
      check({tag, "_q_ready"},    q_ready,    0);
      check({tag, "_p_valid"},    p_valid,    0);
      check({tag, "_p_sat"},      p_sat,      0);
      check({tag, "_coef_valid"}, coef_valid, 0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_timeout"},    timeout,    0);
      check({tag, "_p_y"},        p_y,        0);
   endtask

   // Raise train until reg_start appears; reports edges taken.
   task automatic request(input string tag, output int edges);
      train = 1'b1;
      edges = 0;
      while (!reg_start && edges < 20) begin
         step();
         edges++;
      end
      train = 1'b0;
      check({tag, "_busy_at_start"}, busy, 1);
   endtask

   // Engine drops ready for lo cycles, then presents the fitted coefficients.
   task automatic finish_engine(input string tag, input logic [19:0] b1, input logic [19:0] b0,
                                input int lo);
      reg_ready = 1'b0;
      repeat (lo) step();
      reg_ready = 1'b1;
      reg_b1    = b1;
      reg_b0    = b0;
      for (int i = 0; i < 10 && !coef_valid; i++) step();
      check({tag, "_coef_valid"}, coef_valid, 1);
      check({tag, "_busy_done"},  busy,       0);
      check({tag, "_timeout"},    timeout,    0);
   endtask

   initial begin
      int          edges, got, sent, pulses0, acc;
      logic        held;
      logic [19:0] hold_y, xs[8], b1r, b0r, exp_y;
      logic        hold_s, exp_s;
      logic [20:0] e;

      vt[0] = '{20'h00800, 20'h01400, 1'b0};
      vt[1] = '{20'h00000, 20'h00C00, 1'b0};
      vt[2] = '{20'hFFC00, 20'h00800, 1'b0};
      vt[3] = '{20'hFF000, 20'hFFC00, 1'b0};
      vt[4] = '{20'h00001, 20'h00C01, 1'b0};
      vt[5] = '{20'hFFFFF, 20'h00BFF, 1'b0};
      vt[6] = '{20'h80000, 20'h80C00, 1'b0};
`ifdef REGPRED_SAT_EN
      vt[7] = '{20'h7FFFF, 20'h7FFFF, 1'b1};
`else
      vt[7] = '{20'h7FFFF, 20'h80BFF, 1'b0};
`endif

      rst = 1'b0; train = 1'b0; reg_ready = 1'b1;
      reg_b1 = 20'h12345; reg_b0 = 20'h54321;   // stale engine outputs
      q_valid = 1'b0; q_x = '0; p_ready = 1'b0;
      repeat (3) step();
      check_reset_state("reset");
      rst = 1'b1;
      step();

      // Initial training from IDLE, b1=1.0 b0=3.0
      request("trainA", edges);
      check("trainA_edges", edges, 1);
      finish_engine("trainA", 20'h00400, 20'h00C00, 3);
      check("trainA_pulses", start_pulses, 1);

      foreach (vt[i]) begin
         p_ready = 1'b1; q_valid = 1'b1; q_x = vt[i].x;
         #1;
         check($sformatf("vec%0d_q_ready", i), q_ready, 1);
         step();
         q_valid = 1'b0;
         check($sformatf("vec%0d_lat1", i), p_valid, 0);
         step();
         check($sformatf("vec%0d_p_valid", i), p_valid, 1);
         check($sformatf("vec%0d_p_y", i), p_y, vt[i].y);
         check($sformatf("vec%0d_p_sat", i), p_sat, vt[i].sat);
      end
      step();

      // Retrain from LOADED with an empty pipeline, random coefficients
      b1r = 20'($urandom()); b0r = 20'($urandom());
      request("trainB", edges);
      check("trainB_edges", edges, 2);
      finish_engine("trainB", b1r, b0r, 2);
      check("trainB_pulses", start_pulses, 2);

      foreach (xs[i]) xs[i] = 20'($urandom());
      sent = 0; got = 0; held = 1'b0; hold_y = '0; hold_s = 1'b0;
      for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
         if (held) begin
            check("hold_valid", p_valid, 1);
            check("hold_y", p_y, hold_y);
            check("hold_sat", p_sat, hold_s);
         end
         p_ready = cyc[0];
         q_valid = (sent < 8);
         q_x     = (sent < 8) ? xs[sent] : '0;
         #1;
         if (p_valid && p_ready) begin
            if (sb.size() == 0) check("stream_spurious", 1, 0);
            else begin
               e = sb.pop_front();
               check($sformatf("stream%0d_y", got), p_y, e[19:0]);
               check($sformatf("stream%0d_sat", got), p_sat, e[20]);
            end
            got++;
         end
         if (q_valid && q_ready) begin
            sb.push_back(model(b1r, b0r, q_x));
            sent++;
         end
         held = p_valid && !p_ready;
         hold_y = p_y; hold_s = p_sat;
         step();
      end
      q_valid = 1'b0;
      check("stream_sent", sent, 8);
      check("stream_got", got, 8);
      check("stream_left", sb.size(), 0);

      // Train with two queries in flight and the output stalled
      p_ready = 1'b1; q_valid = 1'b1; q_x = xs[0];
      step();
      q_x = xs[1];
      step();
      q_valid = 1'b0; p_ready = 1'b0; train = 1'b1;
      #1;
      check("drain_q_ready_stalled", q_ready, 0);
      p_ready = 1'b1;
      #1;
      check("drain_q_ready_train", q_ready, 0);
      p_ready = 1'b0;
      pulses0 = start_pulses;
      repeat (3) begin
         step();
         check("drain_no_start", reg_start, 0);
         check("drain_busy", busy, 1);
      end
      e = model(b1r, b0r, xs[0]);
      check("drain_held_y", p_y, e[19:0]);
      p_ready = 1'b1; acc = 0;
      for (int i = 0; i < 20 && !reg_start; i++) begin
         #1;
         if (p_valid && p_ready) begin
            e = model(b1r, b0r, xs[acc[0]]);
            check($sformatf("drain%0d_y", acc), p_y, e[19:0]);
            acc++;
         end
         step();
      end
      train = 1'b0;
      check("drain_start_seen", reg_start, 1);
      check("drain_accepted_before_start", acc, 2);
      finish_engine("trainC", 20'h00400, 20'h00C00, 3);
      check("trainC_pulses", start_pulses, pulses0 + 1);

      // Engine never completes
      request("trainD", edges);
      check("trainD_edges", edges, 2);
      reg_ready = 1'b0;
      repeat (TMO) step();
      check("tmo_not_yet", timeout, 0);
      check("tmo_busy_before", busy, 1);
      step();
      check("tmo_flag", timeout, 1);
      check("tmo_coef_valid", coef_valid, 0);
      check("tmo_busy_after", busy, 0);

      // Recover from ERR; completion on the last allowed cycle beats the timeout
      request("trainE", edges);
      check("trainE_edges", edges, 1);
      check("trainE_tmo_sticky", timeout, 1);
      reg_ready = 1'b0;
      repeat (TMO) step();
      reg_ready = 1'b1; reg_b1 = 20'h7FC00; reg_b0 = 20'h7FC00;
      step();
      check("trainE_coef_valid", coef_valid, 1);
      check("trainE_tmo_cleared", timeout, 0);

`ifdef REGPRED_SAT_EN
      exp_y = 20'h7FFFF; exp_s = 1'b1;
`else
      exp_y = 20'h80000; exp_s = 1'b0;
`endif
      p_ready = 1'b1; q_valid = 1'b1; q_x = 20'h7FC00;
      step();
      q_valid = 1'b0;
      step();
      check("sat_p_valid", p_valid, 1);
      check("sat_p_y", p_y, exp_y);
      check("sat_p_sat", p_sat, exp_s);
      step();

      // Reset while waiting for the engine in WAIT_HI
      request("trainF", edges);
      reg_ready = 1'b0;
      repeat (2) step();
      check("rstF_busy", busy, 1);
      pulses0 = start_pulses;
      rst = 1'b0;
      step();
      check_reset_state("rstF");
      rst = 1'b1;
      reg_ready = 1'b1; reg_b1 = 20'h00400; reg_b0 = 20'h00400;
      q_valid = 1'b1;
      repeat (5) step();
      check("rstF_coef_valid", coef_valid, 0);
      check("rstF_busy_after", busy, 0);
      check("rstF_q_ready", q_ready, 0);
      check("rstF_pulses", start_pulses, pulses0);
      q_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
